// File: rtl/thermo_enc_dec_if.sv
// Request/result bundle between a fabric-port translator and thermo_enc_dec.
// With THERMO_ENC_DEC_MULTIHOT_EN defined, the bundle also carries multi_hot.
interface thermo_enc_dec_if #(
    parameter int unsigned NUM_PORTS = 8
);
    localparam int unsigned WIDTH = $clog2(NUM_PORTS);

    logic                 in_valid;
    logic [NUM_PORTS-1:0] data_in;
    logic                 enc_valid;
    logic [WIDTH-1:0]     enc_idx;
    logic                 enc_zero;
    logic                 dec_valid;
    logic [NUM_PORTS-1:0] thermo_out;
    logic                 dec_zero;
`ifdef THERMO_ENC_DEC_MULTIHOT_EN
    logic                 multi_hot;

    modport master (
        output in_valid, data_in,
        input  enc_valid, enc_idx, enc_zero, dec_valid, thermo_out, dec_zero, multi_hot
    );
    modport slave (
        input  in_valid, data_in,
        output enc_valid, enc_idx, enc_zero, dec_valid, thermo_out, dec_zero, multi_hot
    );
`else
    modport master (
        output in_valid, data_in,
        input  enc_valid, enc_idx, enc_zero, dec_valid, thermo_out, dec_zero
    );
    modport slave (
        input  in_valid, data_in,
        output enc_valid, enc_idx, enc_zero, dec_valid, thermo_out, dec_zero
    );
`endif
endinterface

// File: rtl/thermo_enc_dec.sv
// Two-stage registered priority encoder (MSB wins) followed by a thermometer decoder.
// Optional multi_hot flag is built only when THERMO_ENC_DEC_MULTIHOT_EN is defined.
module thermo_enc_dec #(
    parameter int unsigned NUM_PORTS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    thermo_enc_dec_if.slave bus
);
    localparam int unsigned WIDTH = $clog2(NUM_PORTS);

    logic                 enc_valid_q;
    logic [WIDTH-1:0]     enc_idx_q;
    logic [WIDTH-1:0]     enc_idx_d;
    logic                 enc_zero_q;
    logic                 dec_valid_q;
    logic [NUM_PORTS-1:0] thermo_q;
    logic [NUM_PORTS-1:0] thermo_d;
    logic                 dec_zero_q;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        enc_idx_d = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (bus.data_in[i]) enc_idx_d = WIDTH'(i);
        end
    end

    // Any index at or above NUM_PORTS naturally yields all ones here.
    always_comb begin
        thermo_d = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            thermo_d[k] = (k <= 32'(enc_idx_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_q <= 1'b0;
            enc_idx_q   <= '0;
            enc_zero_q  <= 1'b0;
        end else begin
            enc_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                enc_idx_q  <= enc_idx_d;
                enc_zero_q <= (bus.data_in == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_q <= 1'b0;
            thermo_q    <= '0;
            dec_zero_q  <= 1'b0;
        end else begin
            dec_valid_q <= enc_valid_q;
            if (enc_valid_q) begin
                thermo_q   <= enc_zero_q ? '0 : thermo_d;
                dec_zero_q <= enc_zero_q;
            end
        end
    end

`ifdef THERMO_ENC_DEC_MULTIHOT_EN
    logic multi_hot_q;
    logic multi_hot_d;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot_d = ((bus.data_in & (bus.data_in - NUM_PORTS'(1))) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_hot_q <= 1'b0;
        end else if (bus.in_valid) begin
            multi_hot_q <= multi_hot_d;
        end
    end

    assign bus.multi_hot = multi_hot_q;
`endif

    assign bus.enc_valid  = enc_valid_q;
    assign bus.enc_idx    = enc_idx_q;
    assign bus.enc_zero   = enc_zero_q;
    assign bus.dec_valid  = dec_valid_q;
    assign bus.thermo_out = thermo_q;
    assign bus.dec_zero   = dec_zero_q;

endmodule

// File: tb/tb_thermo_enc_dec.sv
// Directed bench for thermo_enc_dec (NUM_PORTS=8 and 5) with a queue scoreboard.
// Also exercises multi_hot when THERMO_ENC_DEC_MULTIHOT_EN is defined.
module tb_thermo_enc_dec;
    logic clk;
    logic rst_n;

    thermo_enc_dec_if #(.NUM_PORTS(8)) bus ();
    thermo_enc_dec_if #(.NUM_PORTS(5)) bus5 ();

    thermo_enc_dec #(.NUM_PORTS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    thermo_enc_dec #(.NUM_PORTS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    typedef struct {
        logic [2:0] idx;
        logic       zero;
        logic       mh;
    } enc_exp_t;

    typedef struct {
        logic [7:0] th;
        logic       zero;
    } dec_exp_t;

    enc_exp_t enc_q[$];
    dec_exp_t dec_q[$];

    int   checks = 0;
    int   errors = 0;
    logic exp_ev = 1'b0;
    logic exp_dv = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msb_of(input int d);
        return $clog2(d + 1) - 1;
    endfunction

    function automatic logic [7:0] exp_thermo(input int d);
        if (d == 0) return 8'h00;
        return 8'(((1 << (msb_of(d) + 1)) - 1));
    endfunction

    // Drive one cycle of input, then sample at the following falling edge.
    task automatic step(input logic v, input logic [7:0] d);
        enc_exp_t e;
        dec_exp_t x;
        bus.in_valid = v;
        bus.data_in  = d;
        if (v) begin
            e.idx  = (d == 8'h00) ? 3'd0 : 3'(msb_of(int'(d)));
            e.zero = (d == 8'h00);
            e.mh   = ($countones(d) > 1);
            x.th   = exp_thermo(int'(d));
            x.zero = (d == 8'h00);
            enc_q.push_back(e);
            dec_q.push_back(x);
        end
        @(negedge clk);
        exp_dv = exp_ev;
        exp_ev = v;
        chk("enc_valid", 32'(bus.enc_valid), 32'(exp_ev));
        chk("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
        if (bus.enc_valid === 1'b1) begin
            chk("enc_q_nonempty", 32'(enc_q.size() != 0), 32'd1);
            if (enc_q.size() != 0) begin
                e = enc_q.pop_front();
                chk($sformatf("enc_idx d=%0h", d), 32'(bus.enc_idx), 32'(e.idx));
                chk("enc_zero", 32'(bus.enc_zero), 32'(e.zero));
`ifdef THERMO_ENC_DEC_MULTIHOT_EN
                chk("multi_hot", 32'(bus.multi_hot), 32'(e.mh));
`endif
            end
        end
        if (bus.dec_valid === 1'b1) begin
            chk("dec_q_nonempty", 32'(dec_q.size() != 0), 32'd1);
            if (dec_q.size() != 0) begin
                x = dec_q.pop_front();
                chk("thermo_out", 32'(bus.thermo_out), 32'(x.th));
                chk("dec_zero", 32'(bus.dec_zero), 32'(x.zero));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " enc_valid"}, 32'(bus.enc_valid), 32'd0);
        chk({tag, " enc_idx"}, 32'(bus.enc_idx), 32'd0);
        chk({tag, " enc_zero"}, 32'(bus.enc_zero), 32'd0);
        chk({tag, " dec_valid"}, 32'(bus.dec_valid), 32'd0);
        chk({tag, " thermo_out"}, 32'(bus.thermo_out), 32'd0);
        chk({tag, " dec_zero"}, 32'(bus.dec_zero), 32'd0);
`ifdef THERMO_ENC_DEC_MULTIHOT_EN
        chk({tag, " multi_hot"}, 32'(bus.multi_hot), 32'd0);
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus5.in_valid = 1'b0;
        bus5.data_in  = '0;
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single pulse.
        step(1'b1, 8'h01);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Back-to-back burst, then idle cycles with junk data to check hold.
        step(1'b1, 8'h05);
        step(1'b1, 8'h80);
        step(1'b1, 8'h3C);
        step(1'b0, 8'hFF);
        chk("enc_idx_hold", 32'(bus.enc_idx), 32'd5);
        step(1'b0, 8'hFF);
        chk("thermo_hold", 32'(bus.thermo_out), 32'h3F);
        step(1'b0, 8'h00);

        // Zero input.
        step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Exhaustive sweep, pipelined.
        for (int d = 0; d < 256; d++) step(1'b1, 8'(d));
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Reset asserted mid-burst, between edges.
        step(1'b1, 8'h05);
        step(1'b1, 8'h81);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        enc_q.delete();
        dec_q.delete();
        exp_ev = 1'b0;
        exp_dv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        chk_all_zero("post_reset");

        step(1'b1, 8'h03);
        step(1'b1, 8'h40);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        chk("enc_q_drained", 32'(enc_q.size()), 32'd0);
        chk("dec_q_drained", 32'(dec_q.size()), 32'd0);

        // Non-power-of-two port count.
        bus5.in_valid = 1'b1;
        bus5.data_in  = 5'h10;
        @(negedge clk);
        bus5.data_in = 5'h09;
        chk("p5 enc_idx 10", 32'(bus5.enc_idx), 32'd4);
        chk("p5 enc_valid", 32'(bus5.enc_valid), 32'd1);
        @(negedge clk);
        bus5.in_valid = 1'b0;
        chk("p5 enc_idx 09", 32'(bus5.enc_idx), 32'd3);
        chk("p5 thermo 10", 32'(bus5.thermo_out), 32'h1F);
        @(negedge clk);
        chk("p5 thermo 09", 32'(bus5.thermo_out), 32'h0F);
        chk("p5 dec_valid", 32'(bus5.dec_valid), 32'd1);
        @(negedge clk);
        chk("p5 dec_valid end", 32'(bus5.dec_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/thermo_enc_dec.md
Name: thermo_enc_dec

Overview:
- Registered priority-encoder / thermometer-decoder pair for fabric-port translators.
- Stage 1 encodes a NUM_PORTS-bit request vector into the index of its most-significant set bit.
- Stage 2 expands that index into a thermometer mask with bits [index:0] set.
- Both the intermediate index and the final mask are exposed, each with its own valid.

Parameters:
- NUM_PORTS, 8, width of the input vector and of the thermometer output; legal range 2..256.
- WIDTH, $clog2(NUM_PORTS), derived localparam; width of the encoded index; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in qualifies this cycle.
- data_in  input  NUM_PORTS  request vector; any bit pattern legal.
- enc_valid  output  1  enc_idx/enc_zero valid (stage 1).
- enc_idx  output  WIDTH  index of highest set bit of data_in.
- enc_zero  output  1  sampled data_in was all zeros.
- dec_valid  output  1  thermo_out valid (stage 2).
- thermo_out  output  NUM_PORTS  thermometer mask, bits [enc_idx:0] set.
- dec_zero  output  1  stage-2 copy of enc_zero.

Behaviour:
- Reset: asserting rst_n=0 clears all outputs to 0 immediately (asynchronous). Release is synchronised by the user. In-flight data is discarded and nothing re-emerges after reset.
- No backpressure. Pipeline is always enabled; one result per cycle; back-to-back in_valid is fully supported.
- Stage 1, latency 1 cycle, registered every cycle from in_valid:
  - enc_valid <= in_valid.
  - When in_valid=1:
    - enc_idx <= position of MSB set in data_in. Priority is highest index wins; lower bits are ignored.
    - enc_zero <= (data_in == 0).
    - If data_in == 0, enc_idx <= 0.
  - When in_valid=0: enc_idx/enc_zero hold their previous values.
- Stage 2, latency 1 further cycle, 2 cycles from input:
  - dec_valid <= enc_valid.
  - When enc_valid=1:
    - thermo_out[k] <= (k <= enc_idx) for all k, unless enc_zero=1, in which case thermo_out <= 0.
    - dec_zero <= enc_zero.
  - When enc_valid=0: thermo_out/dec_zero hold their previous values.
- Equivalent arithmetic: for nonzero input, thermo_out = (2^(msb+1)) - 1, truncated to NUM_PORTS bits. An all-ones mask results when the MSB is NUM_PORTS-1.
- Non-power-of-two NUM_PORTS: enc_idx never exceeds NUM_PORTS-1. The decoder ignores any idx >= NUM_PORTS and produces all ones for it (defensive case only).
- No X propagation: every output is defined for every input, including zero.
- Pure combinational logic sits between registers; no multicycle paths.

Optional Feature:
- Macro THERMO_ENC_DEC_MULTIHOT_EN.
- Defined:
  - Adds output multi_hot (1 bit), registered alongside stage 1 and cleared by reset.
  - multi_hot <= in_valid && (more than one bit of data_in set).
  - Held when in_valid=0.
  - Encoding/decoding results are unchanged.
- Undefined:
  - Port is absent and no popcount logic is built.
  - All other behaviour is identical.

Test Plan:
- NUM_PORTS=8, single in_valid pulse with data_in=0x01 -> enc_valid next cycle with enc_idx=0, enc_zero=0; dec_valid one cycle later with thermo_out=0x01.
- data_in=0x05, then 0x80, then 0x3C back-to-back:
  - enc_idx = 2, 7, 5 on consecutive cycles.
  - thermo_out = 0x07, 0xFF, 0x3F one cycle later each.
  - enc_valid/dec_valid high for exactly 3 cycles.
- data_in=0x00 with in_valid=1 -> enc_zero=1, enc_idx=0, then thermo_out=0x00, dec_zero=1. With the macro defined, multi_hot=0.
- Exhaustive sweep of data_in 0..255 -> every dec_valid result satisfies the equivalent-arithmetic rule:
  - 1 -> 0x01.
  - 2..3 -> 0x03.
  - 4..7 -> 0x07.
  - 8..15 -> 0x0F.
  - 16..31 -> 0x1F.
  - 32..63 -> 0x3F.
  - 64..127 -> 0x7F.
  - 128..255 -> 0xFF.
  - Zero errors.
- Assert rst_n=0 mid-burst, between stages -> all outputs 0 immediately without a clock edge. After release, no stale dec_valid appears until new in_valid. With the macro defined, 0x03 -> multi_hot=1 and 0x40 -> multi_hot=0.
- NUM_PORTS=5, data_in=0x10 -> enc_idx=4 (WIDTH=3), thermo_out=0x1F. data_in=0x09 -> enc_idx=3, thermo_out=0x0F.
